nash_cipher_stream: RTL and testbench

//  Parametrised, streaming Nash self-synchronising bit cipher. Holds run-time loadable red/blue

---
 rtl/nash_cipher_stream_if.sv | 28 ++
 rtl/nash_cipher_stream.sv | 112 +++++++++++
 tb/tb_nash_cipher_stream.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nash_cipher_stream_if.sv
// Bit-stream handshake bundle for nash_cipher_stream: input bit channel and output bit channel.
// The master side produces input bits and consumes output bits; the slave side is the cipher.
interface nash_cipher_stream_if;
    logic in_valid;
    logic in_ready;
    logic in_bit;
    logic out_valid;
    logic out_ready;
    logic out_bit;

    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bit
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bit
    );
endinterface

// File: rtl/nash_cipher_stream.sv
// Streaming Nash self-synchronising bit cipher with run-time loadable red/blue permutation
// tables, key-seeded shift memory and encrypt/decrypt mode, over valid/ready handshakes.
module nash_cipher_stream #(
    parameter int unsigned STATE_WIDTH = 4,
    parameter int unsigned MEM_DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic                   cfg_sel,
    input  logic [STATE_WIDTH-1:0] cfg_addr,
    input  logic [STATE_WIDTH-1:0] cfg_next,
    input  logic                   cfg_flip,
    input  logic                   key_load,
    input  logic [MEM_DEPTH-1:0]   key_data,
    input  logic                   mode,
    nash_cipher_stream_if.slave    strm,
    output logic                   running
);

    localparam int unsigned Entries = 2 ** STATE_WIDTH;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                 fsm_q;
    logic                   running_q;
    logic [STATE_WIDTH-1:0] curr_q;
    logic [MEM_DEPTH-1:0]   mem_q;
    logic                   mode_q;
    logic                   out_valid_q;
    logic                   out_bit_q;

    logic [STATE_WIDTH-1:0] red_next_q  [Entries];
    logic [STATE_WIDTH-1:0] blue_next_q [Entries];
    logic [Entries-1:0]     red_flip_q;
    logic [Entries-1:0]     blue_flip_q;

    logic                   in_ready;
    logic                   accept;
    logic                   res;
    logic                   fb;
    logic [STATE_WIDTH-1:0] tbl_next;
    logic                   tbl_flip;
    logic [MEM_DEPTH-1:0]   mem_shift;

    // Key load blocks acceptance so a re-key never races with a data bit.
    assign in_ready = running_q & ~key_load & (~out_valid_q | strm.out_ready);
    assign accept   = strm.in_valid & in_ready;

    // fb is always the ciphertext bit, so encrypt and decrypt walk identical state sequences.
    always_comb begin
        res       = strm.in_bit ^ mem_q[0];
        fb        = mode_q ? strm.in_bit : res;
        tbl_next  = fb ? red_next_q[curr_q] : blue_next_q[curr_q];
        tbl_flip  = fb ? red_flip_q[curr_q] : blue_flip_q[curr_q];
        mem_shift = (mem_q >> 1) | (MEM_DEPTH'(fb ^ tbl_flip) << (MEM_DEPTH - 1));
    end

    // Permutation tables: writable only while idle, identity after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                red_next_q[i]  <= STATE_WIDTH'(i);
                blue_next_q[i] <= STATE_WIDTH'(i);
            end
            red_flip_q  <= '0;
            blue_flip_q <= '0;
        end else if (cfg_we && fsm_q == StIdle) begin
            if (cfg_sel) begin
                red_next_q[cfg_addr] <= cfg_next;
                red_flip_q[cfg_addr] <= cfg_flip;
            end else begin
                blue_next_q[cfg_addr] <= cfg_next;
                blue_flip_q[cfg_addr] <= cfg_flip;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            running_q   <= 1'b0;
            curr_q      <= '0;
            mem_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            if (key_load) begin
                fsm_q       <= StRun;
                running_q   <= 1'b1;
                mem_q       <= key_data;
                curr_q      <= '0;
                mode_q      <= mode;
                out_valid_q <= 1'b0;
            end else if (accept) begin
                curr_q      <= tbl_next;
                mem_q       <= mem_shift;
                out_bit_q   <= res;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && strm.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign strm.in_ready  = in_ready;
    assign strm.out_valid = out_valid_q;
    assign strm.out_bit   = out_bit_q;
    assign running        = running_q;

endmodule

// File: tb/tb_nash_cipher_stream.sv
// Self-checking bench for nash_cipher_stream: scoreboard of expected output bits fed from
// constant key patterns, a behavioural cipher model, or captured plaintext.
module tb_nash_cipher_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_sel = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [3:0] cfg_next = '0;
    logic       cfg_flip = 1'b0;
    logic       key_load = 1'b0;
    logic [7:0] key_data = '0;
    logic       mode = 1'b0;
    logic       running;

    nash_cipher_stream_if sif ();

    nash_cipher_stream #(
        .STATE_WIDTH(4),
        .MEM_DEPTH  (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_we  (cfg_we),
        .cfg_sel (cfg_sel),
        .cfg_addr(cfg_addr),
        .cfg_next(cfg_next),
        .cfg_flip(cfg_flip),
        .key_load(key_load),
        .key_data(key_data),
        .mode    (mode),
        .strm    (sif),
        .running (running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit sb_q[$];
    bit stim_q[$];
    bit exp_all[$];
    bit got_q[$];

    logic [3:0] m_next [2][16];
    bit         m_flip [2][16];
    logic [7:0] m_mem;
    logic [3:0] m_state;
    bit         m_mode;

    function automatic void model_identity();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                m_next[s][i] = 4'(i);
                m_flip[s][i] = 1'b0;
            end
        end
    endfunction

    function automatic bit model_step(bit b);
        bit res;
        bit fb;
        bit f;
        res     = b ^ m_mem[0];
        fb      = m_mode ? b : res;
        f       = m_flip[fb][m_state];
        m_state = m_next[fb][m_state];
        m_mem   = {fb ^ f, m_mem[7:1]};
        return res;
    endfunction

    function automatic void model_fill();
        exp_all.delete();
        foreach (stim_q[i]) exp_all.push_back(model_step(stim_q[i]));
    endfunction

    // Identity tables with all-zero plaintext just rotate the key out LSB first.
    function automatic void pattern_fill(logic [7:0] key);
        exp_all.delete();
        foreach (stim_q[i]) exp_all.push_back(key[i % 8]);
    endfunction

    function automatic void stim_random(int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(1'($urandom));
    endfunction

    function automatic void stim_zero(int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(1'b0);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        cfg_we       = 1'b0;
        key_load     = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_bit   = 1'b0;
        sif.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_identity();
    endtask

    task automatic do_key(input logic [7:0] key, input bit md);
        @(negedge clk);
        sif.in_valid = 1'b0;
        key_load     = 1'b1;
        key_data     = key;
        mode         = md;
        @(negedge clk);
        key_load = 1'b0;
        #1;
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL key_running: running=%b expected 1", running);
        end
        m_mem   = key;
        m_state = '0;
        m_mode  = md;
    endtask

    task automatic cfg_write(input bit sel, input logic [3:0] addr, input logic [3:0] nxt,
                             input bit flp, input bit update_model);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_next = nxt;
        cfg_flip = flp;
        @(negedge clk);
        cfg_we = 1'b0;
        if (update_model) begin
            m_next[sel][addr] = nxt;
            m_flip[sel][addr] = flp;
        end
    endtask

    // Push stim_q through the DUT; each accepted bit pushes its expected output to sb_q.
    task automatic stream(input int ready_pct, input string name, output int cycles);
        int  sent = 0;
        int  rcvd = 0;
        int  n = stim_q.size();
        bit  stalled = 1'b0;
        bit  held = 1'b0;
        bit  e;
        cycles = 0;
        got_q.delete();
        sb_q.delete();
        while ((sent < n || rcvd < n) && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            sif.in_valid  = (sent < n);
            sif.in_bit    = (sent < n) ? stim_q[sent] : 1'b0;
            sif.out_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (stalled) begin
                checks++;
                if (sif.out_valid !== 1'b1 || sif.out_bit !== held) begin
                    errors++;
                    $display("FAIL %s stall_hold: valid=%b bit=%b expected valid=1 bit=%b",
                             name, sif.out_valid, sif.out_bit, held);
                end
            end
            stalled = 1'b0;
            if (sif.out_valid === 1'b1 && !sif.out_ready) begin
                checks++;
                if (sif.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s stall_in_ready: in_ready=%b expected 0", name, sif.in_ready);
                end
                stalled = 1'b1;
                held    = sif.out_bit;
            end
            if (sif.out_valid === 1'b1 && sif.out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s dup_output: got bit %b with nothing expected", name,
                             sif.out_bit);
                end else begin
                    e = sb_q.pop_front();
                    if (sif.out_bit !== e) begin
                        errors++;
                        $display("FAIL %s out_bit[%0d]: got %b expected %b", name, rcvd,
                                 sif.out_bit, e);
                    end
                end
                got_q.push_back(sif.out_bit);
                rcvd++;
            end
            if (sif.in_valid && sif.in_ready === 1'b1) begin
                sb_q.push_back(exp_all[sent]);
                sent++;
            end
        end
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        checks++;
        if (rcvd != n || sent != n || sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s completion: sent=%0d rcvd=%0d pending=%0d expected %0d each",
                     name, sent, rcvd, sb_q.size(), n);
        end
    endtask

    task automatic test_reset();
        sif.in_valid  = 1'b1;
        sif.in_bit    = 1'b1;
        sif.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_identity();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({running, sif.in_ready, sif.out_valid, sif.out_bit} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle[%0d]: run/rdy/vld/bit=%b%b%b%b expected 0000", i,
                         running, sif.in_ready, sif.out_valid, sif.out_bit);
            end
        end
        sif.in_valid = 1'b0;
    endtask

    task automatic test_identity();
        int cyc;
        do_key(8'hA5, 1'b0);
        stim_zero(16);
        pattern_fill(8'hA5);
        stream(100, "identity", cyc);
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL identity_throughput: cycles=%0d expected 17", cyc);
        end
    endtask

    task automatic test_back_pressure();
        int cyc;
        do_key(8'hA5, 1'b0);
        stim_zero(48);
        pattern_fill(8'hA5);
        stream(45, "backpressure", cyc);
    endtask

    task automatic test_random_tables();
        int cyc;
        bit plain[$];
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                cfg_write(1'(s), 4'(a), 4'($urandom), 1'($urandom), 1'b1);
            end
        end
        cfg_write(1'b1, 4'h0, 4'h2, 1'b0, 1'b1);
        cfg_write(1'b0, 4'h0, 4'h2, 1'b0, 1'b1);
        do_key(8'h3C, 1'b0);
        stim_random(64);
        plain = stim_q;
        model_fill();
        stream(100, "encrypt", cyc);
        stim_q = got_q;
        do_key(8'h3C, 1'b1);
        exp_all = plain;
        stream(70, "decrypt", cyc);
    endtask

    task automatic test_rekey();
        int cyc;
        do_key(8'h5A, 1'b0);
        stim_random(4);
        model_fill();
        stream(100, "prekey", cyc);
        @(negedge clk);
        sif.in_valid  = 1'b1;
        sif.in_bit    = 1'($urandom);
        sif.out_ready = 1'b0;
        #1;
        checks++;
        if (sif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rekey_accept5: in_ready=%b expected 1", sif.in_ready);
        end
        @(negedge clk);
        key_load = 1'b1;
        key_data = 8'h96;
        mode     = 1'b0;
        #1;
        checks++;
        if (sif.out_valid !== 1'b1 || sif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rekey_pending: out_valid=%b in_ready=%b expected 1 0",
                     sif.out_valid, sif.in_ready);
        end
        @(negedge clk);
        key_load      = 1'b0;
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        #1;
        checks++;
        if (sif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rekey_dropped: out_valid=%b expected 0", sif.out_valid);
        end
        m_mem   = 8'h96;
        m_state = '0;
        m_mode  = 1'b0;
        stim_random(24);
        model_fill();
        stream(80, "rekey", cyc);
    endtask

    task automatic test_cfg_in_run();
        int cyc;
        do_key(8'hC3, 1'b0);
        cfg_write(1'b1, 4'h0, 4'hF, 1'b1, 1'b0);
        cfg_write(1'b0, 4'h0, 4'hF, 1'b1, 1'b0);
        stim_random(40);
        model_fill();
        stream(100, "cfg_in_run", cyc);
    endtask

    task automatic test_async_reset();
        int cyc;
        do_key(8'h3C, 1'b0);
        @(negedge clk);
        sif.in_valid  = 1'b1;
        sif.in_bit    = 1'b1;
        sif.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({running, sif.in_ready, sif.out_valid, sif.out_bit} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: run/rdy/vld/bit=%b%b%b%b expected 0000", running,
                     sif.in_ready, sif.out_valid, sif.out_bit);
        end
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_identity();
        do_key(8'hA5, 1'b0);
        stim_zero(16);
        pattern_fill(8'hA5);
        stream(100, "post_reset_identity", cyc);
    endtask

    initial begin
        sif.in_valid  = 1'b0;
        sif.in_bit    = 1'b0;
        sif.out_ready = 1'b1;
        test_reset();
        test_identity();
        test_back_pressure();
        apply_reset();
        test_random_tables();
        test_rekey();
        test_cfg_in_run();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
